// File: rtl/barcode.sv
// Serial barcode decoder: learns the bit period from the start pulse, samples 8 bits MSB-first.
// Optional BARCODE_TIMEOUT_EN aborts a frame when the timer saturates mid-frame.
module barcode #(
    parameter int TIMER_W = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_FALL = 3'd2,
        SAMPLE    = 3'd3,
        CHECK     = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic bc_m, BC_s, BC_p;
    logic fall, rise;

    logic [TIMER_W-1:0] timer, period, tmr_inc;
    logic [7:0] shift;
    logic [2:0] bit_cnt;

    logic tmr_sat, sample_hit, abort;
    logic tmr_clr, tmr_run, cnt_clr, cap_period, do_shift, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_m <= 1'b1;
            BC_s <= 1'b1;
            BC_p <= 1'b1;
        end else begin
            bc_m <= BC;
            BC_s <= bc_m;
            BC_p <= BC_s;
        end
    end

    assign fall = BC_p & ~BC_s;
    assign rise = ~BC_p & BC_s;

    assign tmr_sat    = &timer;
    assign tmr_inc    = tmr_sat ? timer : timer + TIMER_W'(1);
    assign sample_hit = (timer == period);

`ifdef BARCODE_TIMEOUT_EN
    assign abort = tmr_sat;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fall)
                    state_d = START;
            end
            START: begin
                if (abort)
                    state_d = IDLE;
                else if (rise)
                    state_d = WAIT_FALL;
            end
            WAIT_FALL: begin
                if (abort)
                    state_d = IDLE;
                else if (fall)
                    state_d = SAMPLE;
            end
            SAMPLE: begin
                if (abort)
                    state_d = IDLE;
                else if (sample_hit)
                    state_d = (bit_cnt == 3'd7) ? CHECK : WAIT_FALL;
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tmr_clr    = 1'b0;
        tmr_run    = 1'b0;
        cnt_clr    = 1'b0;
        cap_period = 1'b0;
        do_shift   = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmr_clr = fall;
                cnt_clr = fall;
            end
            START: begin
                tmr_run    = 1'b1;
                cap_period = rise & ~abort;
            end
            WAIT_FALL: begin
                tmr_run = 1'b1;
                tmr_clr = fall & ~abort;
            end
            SAMPLE: begin
                tmr_run  = 1'b1;
                do_shift = sample_hit & ~abort;
            end
            CHECK: begin
                accept = (shift[7:6] == 2'b00);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            period  <= '0;
            shift   <= 8'h00;
            bit_cnt <= 3'd0;
        end else begin
            if (tmr_clr)
                timer <= '0;
            else if (tmr_run)
                timer <= tmr_inc;
            if (cap_period)
                period <= timer;
            if (cnt_clr)
                bit_cnt <= 3'd0;
            else if (do_shift)
                bit_cnt <= bit_cnt + 3'd1;
            if (do_shift)
                shift <= {shift[6:0], BC_s};
        end
    end

    // An accepted frame outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID     <= 8'h00;
            ID_vld <= 1'b0;
        end else begin
            if (accept) begin
                ID     <= shift;
                ID_vld <= 1'b1;
            end else if (clr_ID_vld) begin
                ID_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_barcode.sv
// Directed bench for barcode: accept/reject, clear collision, mid-frame reset,
// short periods and stuck-low start behaviour.
`timescale 1ns/1ps
module tb_barcode;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       BC = 1'b1;
    logic       clr_ID_vld = 1'b0;
    logic [7:0] ID;
    logic       ID_vld;

    int errors = 0;
    int checks = 0;
    int seen;

    barcode #(.TIMER_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .BC         (BC),
        .clr_ID_vld (clr_ID_vld),
        .ID         (ID),
        .ID_vld     (ID_vld)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Line changes land ph ns after a rising edge, never on an edge.
    task automatic align(input int ph);
        @(posedge clk);
        #(ph);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb,
                              input int st, input int lo1,
                              input int lo0, input int slot);
        int lo;
        BC = 1'b0;
        #(st * 10);
        BC = 1'b1;
        #((slot - st) * 10);
        for (int i = 7; i > 7 - nb; i--) begin
            lo = d[i] ? lo1 : lo0;
            BC = 1'b0;
            #(lo * 10);
            BC = 1'b1;
            #((slot - lo) * 10);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        settle(3);
        chk8("reset_id", ID, 8'h00);
        chk1("reset_vld", ID_vld, 1'b0);
        rst_n = 1'b1;
        settle(5);

        align(3);
        send_frame(8'h2D, 8, 100, 50, 150, 200);
        settle(5);
        chk8("accept_id", ID, 8'h2D);
        chk1("accept_vld", ID_vld, 1'b1);
        settle(50);
        chk1("vld_sticky", ID_vld, 1'b1);

        clr_ID_vld = 1'b1;
        @(negedge clk);
        clr_ID_vld = 1'b0;
        chk1("clear_pulse", ID_vld, 1'b0);

        align(7);
        send_frame(8'h49, 8, 100, 50, 150, 200);
        settle(5);
        chk8("reject_id", ID, 8'h2D);
        chk1("reject_vld", ID_vld, 1'b0);

        align(2);
        send_frame(8'h09, 8, 100, 50, 150, 200);
        settle(5);
        chk8("accept09_id", ID, 8'h09);
        chk1("accept09_vld", ID_vld, 1'b1);

        clr_ID_vld = 1'b1;
        settle(2);
        chk1("clr_held", ID_vld, 1'b0);
        seen = 0;
        align(4);
        fork
            send_frame(8'h3F, 8, 100, 50, 150, 200);
            begin
                for (int i = 0; i < 4000; i++) begin
                    @(negedge clk);
                    if (ID_vld) begin
                        seen = 1;
                        clr_ID_vld = 1'b0;
                        break;
                    end
                end
                clr_ID_vld = 1'b0;
            end
        join
        chk1("collision_seen", seen[0], 1'b1);
        settle(3);
        chk8("collision_id", ID, 8'h3F);
        chk1("collision_vld", ID_vld, 1'b1);

        align(6);
        send_frame(8'h12, 4, 100, 50, 150, 200);
        @(negedge clk);
        rst_n = 1'b0;
        settle(2);
        chk8("midrst_id", ID, 8'h00);
        chk1("midrst_vld", ID_vld, 1'b0);
        rst_n = 1'b1;
        settle(10);
        chk1("postrst_vld", ID_vld, 1'b0);
        align(1);
        send_frame(8'h12, 8, 100, 50, 150, 200);
        settle(5);
        chk8("after_rst_id", ID, 8'h12);
        chk1("after_rst_vld", ID_vld, 1'b1);

        clr_ID_vld = 1'b1;
        @(negedge clk);
        clr_ID_vld = 1'b0;
        align(3);
        send_frame(8'h15, 8, 3, 1, 5, 8);
        settle(10);
        chk8("short_id", ID, 8'h15);
        chk1("short_vld", ID_vld, 1'b1);

        clr_ID_vld = 1'b1;
        @(negedge clk);
        clr_ID_vld = 1'b0;
        align(8);
        send_frame(8'h35, 8, 3, 1, 5, 8);
        settle(10);
        chk8("short2_id", ID, 8'h35);
        chk1("short2_vld", ID_vld, 1'b1);

        clr_ID_vld = 1'b1;
        @(negedge clk);
        clr_ID_vld = 1'b0;
        align(5);
        BC = 1'b0;
        #(400 * 10);
        BC = 1'b1;
        settle(20);
        chk1("stuck_vld", ID_vld, 1'b0);
        chk8("stuck_id", ID, 8'h35);
`ifndef BARCODE_TIMEOUT_EN
        // Period latched at all-ones: flush the frame with short pulses.
        for (int i = 0; i < 8; i++) begin
            BC = 1'b0;
            #(10 * 10);
            BC = 1'b1;
            #(290 * 10);
        end
        settle(5);
        chk1("flush_vld", ID_vld, 1'b0);
        chk8("flush_id", ID, 8'h35);
`endif
        align(2);
        send_frame(8'h21, 8, 100, 50, 150, 200);
        settle(5);
        chk8("recover_id", ID, 8'h21);
        chk1("recover_vld", ID_vld, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
